// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline: load-width encodings and the
// write-back stall FSM state type.
package pipeline_pkg;

    // Load width encodings carried from MEM into WB (2'b11 is reserved
    // and behaves as a word load).
    localparam logic [1:0] LW_WORD = 2'b00;
    localparam logic [1:0] LW_HALF = 2'b01;
    localparam logic [1:0] LW_BYTE = 2'b10;

    // Write-back stage state: RUN retires freely, WAIT is stalled on a load.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_aligner.sv
// Combinational load aligner: picks the addressed byte/half out of the raw
// memory word, sign- or zero-extends it, and flags misaligned accesses.
module load_aligner
    import pipeline_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_width,
    input  logic        i_unsigned,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane select followed by extension according to the load width.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_data       = i_data;
        o_misaligned = 1'b0;
        w_half       = i_off[1] ? i_data[31:16] : i_data[15:0];
        case (i_off)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            default: w_byte = i_data[31:24];
        endcase

        case (i_width)
            LW_HALF: begin
                o_data       = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_misaligned = i_off[0];
            end
            LW_BYTE: begin
                o_data       = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_misaligned = 1'b0;
            end
            default: begin
                // Word and the reserved encoding both need a 4-byte aligned address.
                o_data       = i_data;
                o_misaligned = |i_off;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load-data selection and the
// bounded stall on slow data memory with sticky error flags.
module wb_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_shouldWriteRegister,
    input  logic [4:0]  mem_registerWriteAddress,
    input  logic [31:0] mem_aluOut,
    input  logic        mem_memOutOrAluOutWriteBackToRegFile,
    input  logic [1:0]  mem_loadWidth,
    input  logic        mem_loadUnsigned,
    input  logic [31:0] Data_in,
    input  logic        MIO_ready,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_registerWriteAddress,
    output logic [31:0] wb_writeRegData,
    output logic        memStall,
    output logic [31:0] retiredCount,
    output logic        loadTimeout,
    output logic        loadMisaligned
);

    localparam int               CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(TIMEOUT_CYCLES);

    // MEM/WB pipeline register
    logic        r_valid;
    logic        r_reg_write;
    logic [4:0]  r_addr;
    logic [31:0] r_alu_out;
    logic        r_is_load;
    logic [1:0]  r_width;
    logic        r_unsigned;

    // Stall control and status
    wb_state_t   r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0] r_retired;
    logic        r_load_timeout;
    logic        r_load_misaligned;

    logic [31:0] w_align_data;
    logic        w_align_mis;
    logic        w_misaligned;
    logic        w_load_live;

    load_aligner u_load_aligner (
        .i_data       (Data_in),
        .i_off        (r_alu_out[1:0]),
        .i_width      (r_width),
        .i_unsigned   (r_unsigned),
        .o_data       (w_align_data),
        .o_misaligned (w_align_mis)
    );

    // A misaligned load never waits for memory: it is suppressed and retires at once.
    assign w_misaligned = r_is_load & w_align_mis;
    assign w_load_live  = r_valid & r_is_load & ~w_misaligned;

    assign memStall = w_load_live & ~MIO_ready & (r_wait_cnt < CNT_MAX);

    assign wb_RegWrite = r_valid & r_reg_write & (r_addr != 5'd0)
                       & (~r_is_load | MIO_ready) & ~w_misaligned;
    assign wb_registerWriteAddress = r_addr;
    assign wb_writeRegData         = r_is_load ? w_align_data : r_alu_out;

    assign retiredCount   = r_retired;
    assign loadTimeout    = r_load_timeout;
    assign loadMisaligned = r_load_misaligned;

    // MEM/WB register: capture the MEM instruction unless the stage is frozen.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_addr      <= 5'd0;
            r_alu_out   <= 32'd0;
            r_is_load   <= 1'b0;
            r_width     <= LW_WORD;
            r_unsigned  <= 1'b0;
        end else if (!memStall) begin
            r_valid     <= mem_valid;
            r_reg_write <= mem_shouldWriteRegister;
            r_addr      <= mem_registerWriteAddress;
            r_alu_out   <= mem_aluOut;
            r_is_load   <= mem_memOutOrAluOutWriteBackToRegFile;
            r_width     <= mem_loadWidth;
            r_unsigned  <= mem_loadUnsigned;
        end
    end

    // Stall FSM: count stall cycles and abandon the load once the budget is spent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_load_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (memStall) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (memStall) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                        // Leaving WAIT without data means the budget ran out.
                        if (w_load_live && !MIO_ready) begin
                            r_load_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Retirement counter and sticky misaligned flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired         <= 32'd0;
            r_load_misaligned <= 1'b0;
        end else begin
            if (r_valid && !memStall) begin
                r_retired <= r_retired + 32'd1;
            end
            if (r_valid && w_misaligned) begin
                r_load_misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// stall/timeout/reset sequences and randomized instructions against a
// behavioural model of the write-back rules.
module tb_wb_stage;
    import pipeline_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_shouldWriteRegister;
    logic [4:0]  mem_registerWriteAddress;
    logic [31:0] mem_aluOut;
    logic        mem_memOutOrAluOutWriteBackToRegFile;
    logic [1:0]  mem_loadWidth;
    logic        mem_loadUnsigned;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        wb_RegWrite;
    logic [4:0]  wb_registerWriteAddress;
    logic [31:0] wb_writeRegData;
    logic        memStall;
    logic [31:0] retiredCount;
    logic        loadTimeout;
    logic        loadMisaligned;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int unsigned m_retired = 0;
    logic        m_to      = 1'b0;
    logic        m_mis     = 1'b0;

    wb_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk                                  (clk),
        .rst                                  (rst),
        .mem_valid                            (mem_valid),
        .mem_shouldWriteRegister              (mem_shouldWriteRegister),
        .mem_registerWriteAddress             (mem_registerWriteAddress),
        .mem_aluOut                           (mem_aluOut),
        .mem_memOutOrAluOutWriteBackToRegFile (mem_memOutOrAluOutWriteBackToRegFile),
        .mem_loadWidth                        (mem_loadWidth),
        .mem_loadUnsigned                     (mem_loadUnsigned),
        .Data_in                              (Data_in),
        .MIO_ready                            (MIO_ready),
        .wb_RegWrite                          (wb_RegWrite),
        .wb_registerWriteAddress              (wb_registerWriteAddress),
        .wb_writeRegData                      (wb_writeRegData),
        .memStall                             (memStall),
        .retiredCount                         (retiredCount),
        .loadTimeout                          (loadTimeout),
        .loadMisaligned                       (loadMisaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  addr;
        logic        rw;
        logic        ld;
        logic [1:0]  w;
        logic        uns;
        logic [31:0] din;
        int          k;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Load value from memory word by byte address, width and signedness.
    function automatic logic [31:0] ref_load(input logic [31:0] din, input logic [31:0] a,
                                             input logic [1:0] w, input logic uns);
        logic [63:0] v;
        int unsigned off = a % 4;
        if (w == LW_HALF) begin
            v = 64'(din >> (16 * (off / 2))) % 65536;
            if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
        end else if (w == LW_BYTE) begin
            v = 64'(din >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
        end else begin
            v = 64'(din);
        end
        return v[31:0];
    endfunction

    function automatic logic is_mis(input logic ld, input logic [1:0] w, input logic [31:0] a);
        int unsigned off = a % 4;
        if (!ld)              return 1'b0;
        if (w == LW_BYTE)     return 1'b0;
        if (w == LW_HALF)     return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic drive_mem(input logic v, input logic [31:0] alu, input logic [4:0] addr,
                             input logic rw, input logic ld, input logic [1:0] w, input logic uns);
        mem_valid                            = v;
        mem_aluOut                           = alu;
        mem_registerWriteAddress             = addr;
        mem_shouldWriteRegister              = rw;
        mem_memOutOrAluOutWriteBackToRegFile = ld;
        mem_loadWidth                        = w;
        mem_loadUnsigned                     = uns;
    endtask

    // Issue one instruction, present memory data k cycles late, check the stall
    // length, the write port on the retiring cycle, the counter and the flags.
    task automatic run_instr(input string name, input logic [31:0] alu, input logic [4:0] addr,
                             input logic rw, input logic ld, input logic [1:0] w, input logic uns,
                             input logic [31:0] din, input int k,
                             input logic exp_we, input logic [31:0] exp_data);
        logic mis;
        int   exp_stall;
        int   stalls;
        logic done;
        mis       = is_mis(ld, w, alu);
        exp_stall = (ld && !mis) ? ((k < T) ? k : T) : 0;
        @(negedge clk);
        drive_mem(1'b1, alu, addr, rw, ld, w, uns);
        MIO_ready = 1'b0;
        @(negedge clk);
        mem_valid = 1'b0;
        stalls = 0;
        done   = 1'b0;
        for (int j = 0; j < 40 && !done; j++) begin
            if (j > 0) @(negedge clk);
            Data_in   = din;
            MIO_ready = ld ? (j == k) : 1'($urandom_range(0, 1));
            #1;
            if (memStall) begin
                stalls++;
                check({name, "_stall_we"}, 32'(wb_RegWrite), 32'd0);
            end else begin
                done = 1'b1;
                check({name, "_stall_len"}, stalls, exp_stall);
                check({name, "_we"}, 32'(wb_RegWrite), 32'(exp_we));
                if (exp_we) begin
                    check({name, "_addr"}, 32'(wb_registerWriteAddress), 32'(addr));
                    check({name, "_data"}, wb_writeRegData, exp_data);
                end
            end
        end
        if (!done) check({name, "_stall_bound"}, stalls, exp_stall);
        m_retired++;
        if (ld && mis) m_mis = 1'b1;
        if (ld && !mis && k > T) m_to = 1'b1;
        @(posedge clk);
        #1;
        MIO_ready = 1'b0;
        check({name, "_retired"}, retiredCount, m_retired);
        check({name, "_timeout_flag"}, 32'(loadTimeout), 32'(m_to));
        check({name, "_misaligned_flag"}, 32'(loadMisaligned), 32'(m_mis));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        logic [31:0] alu, din, edata;
        logic [4:0]  addr;
        logic [1:0]  w;
        logic        rw, ld, uns, mis, ewe;
        int          k;

        //        alu           addr  rw ld  w        uns din            k  we  data
        vecs[0]  = '{32'h0000_1234, 5'd5,  1, 0, LW_WORD, 0, 32'h0,          0, 1, 32'h0000_1234};
        vecs[1]  = '{32'h0000_1003, 5'd7,  1, 1, LW_BYTE, 0, 32'h80FF_FF00,  0, 1, 32'hFFFF_FF80};
        vecs[2]  = '{32'h0000_2001, 5'd8,  1, 1, LW_BYTE, 1, 32'h1234_5678,  0, 1, 32'h0000_0056};
        vecs[3]  = '{32'h0000_2002, 5'd9,  1, 1, LW_HALF, 0, 32'h8001_7FFF,  0, 1, 32'hFFFF_8001};
        vecs[4]  = '{32'h0000_2000, 5'd10, 1, 1, LW_HALF, 1, 32'h8001_F00D,  0, 1, 32'h0000_F00D};
        vecs[5]  = '{32'h0000_2004, 5'd11, 1, 1, LW_WORD, 0, 32'hDEAD_BEEF,  0, 1, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h0000_2008, 5'd12, 1, 1, 2'b11,   0, 32'hCAFE_F00D,  0, 1, 32'hCAFE_F00D};
        vecs[7]  = '{32'h0000_1002, 5'd13, 1, 1, LW_WORD, 0, 32'h1111_1111,  5, 0, 32'h0};
        vecs[8]  = '{32'h0000_3001, 5'd14, 1, 1, LW_HALF, 0, 32'h2222_2222,  5, 0, 32'h0};
        vecs[9]  = '{32'h0000_00AA, 5'd0,  1, 0, LW_WORD, 0, 32'h0,          0, 0, 32'h0};
        vecs[10] = '{32'h0000_00BB, 5'd3,  0, 0, LW_WORD, 0, 32'h0,          0, 0, 32'h0};
        vecs[11] = '{32'h0000_4000, 5'd15, 1, 1, LW_BYTE, 0, 32'h0000_007F,  2, 1, 32'h0000_007F};

        rst = 1'b1;
        drive_mem(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, LW_WORD, 1'b0);
        Data_in   = 32'h0;
        MIO_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",      32'(wb_RegWrite), 32'd0);
        check("rst_stall",   32'(memStall), 32'd0);
        check("rst_addr",    32'(wb_registerWriteAddress), 32'd0);
        check("rst_data",    wb_writeRegData, 32'd0);
        check("rst_retired", retiredCount, 32'd0);
        check("rst_flags",   32'({loadTimeout, loadMisaligned}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].alu, vecs[i].addr, vecs[i].rw, vecs[i].ld,
                      vecs[i].w, vecs[i].uns, vecs[i].din, vecs[i].k,
                      vecs[i].exp_we, vecs[i].exp_data);
        end

        // Half load delayed 3 cycles while MEM already offers the next instruction.
        @(negedge clk);
        drive_mem(1'b1, 32'h0000_4002, 5'd12, 1'b1, 1'b1, LW_HALF, 1'b1);
        Data_in   = 32'hBEEF_0000;
        MIO_ready = 1'b0;
        @(negedge clk);
        drive_mem(1'b1, 32'h0000_0055, 5'd9, 1'b1, 1'b0, LW_WORD, 1'b0);
        stalls = 0;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            MIO_ready = (j == 3);
            #1;
            if (!memStall) break;
            stalls++;
            check("hold_addr", 32'(wb_registerWriteAddress), 32'd12);
        end
        check("hold_stall_len", stalls, 3);
        check("hold_we",   32'(wb_RegWrite), 32'd1);
        check("hold_addr_final", 32'(wb_registerWriteAddress), 32'd12);
        check("hold_data", wb_writeRegData, 32'h0000_BEEF);
        @(negedge clk);
        mem_valid = 1'b0;
        MIO_ready = 1'b0;
        #1;
        check("follow_we",   32'(wb_RegWrite), 32'd1);
        check("follow_addr", 32'(wb_registerWriteAddress), 32'd9);
        check("follow_data", wb_writeRegData, 32'h0000_0055);
        m_retired += 2;
        @(posedge clk);
        #1;
        check("hold_retired", retiredCount, m_retired);

        // Load that never gets data, then an instruction that must proceed.
        run_instr("timeout", 32'h0000_5000, 5'd6, 1'b1, 1'b1, LW_WORD, 1'b0,
                  32'h1234_5678, 1000, 1'b0, 32'h0);
        run_instr("after_to", 32'h0000_0777, 5'd6, 1'b1, 1'b0, LW_WORD, 1'b0,
                  32'h0, 0, 1'b1, 32'h0000_0777);
        // Data arriving exactly as the budget expires still writes.
        run_instr("edge_ready", 32'h0000_6000, 5'd2, 1'b1, 1'b1, LW_WORD, 1'b0,
                  32'hA5A5_5A5A, T, 1'b1, 32'hA5A5_5A5A);

        // Randomized instructions against the model.
        for (int i = 0; i < 80; i++) begin
            alu  = $urandom;
            addr = 5'($urandom_range(0, 31));
            rw   = 1'($urandom_range(0, 1));
            ld   = 1'($urandom_range(0, 1));
            w    = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            din  = $urandom;
            k    = $urandom_range(0, 20);
            if ($urandom_range(0, 3) != 0) begin
                if (w == LW_HALF)      alu = alu & 32'hFFFF_FFFE;
                else if (w != LW_BYTE) alu = alu & 32'hFFFF_FFFC;
            end
            mis   = is_mis(ld, w, alu);
            ewe   = rw && (addr != 5'd0) && !mis && (!ld || k <= T);
            edata = ld ? ref_load(din, alu, w, uns) : alu;
            run_instr($sformatf("rnd%0d", i), alu, addr, rw, ld, w, uns, din, k, ewe, edata);
        end

        // Reset while a load is waiting.
        @(negedge clk);
        drive_mem(1'b1, 32'h0000_7000, 5'd4, 1'b1, 1'b1, LW_WORD, 1'b0);
        MIO_ready = 1'b0;
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rstwait_stall", 32'(memStall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        MIO_ready = 1'b1;
        #1;
        check("rstwait_we",      32'(wb_RegWrite), 32'd0);
        check("rstwait_stall0",  32'(memStall), 32'd0);
        check("rstwait_addr",    32'(wb_registerWriteAddress), 32'd0);
        check("rstwait_data",    wb_writeRegData, 32'd0);
        check("rstwait_retired", retiredCount, 32'd0);
        check("rstwait_flags",   32'({loadTimeout, loadMisaligned}), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        MIO_ready = 1'b0;
        m_retired = 0;
        m_to      = 1'b0;
        m_mis     = 1'b0;
        run_instr("post_rst", 32'h0000_0321, 5'd1, 1'b1, 1'b0, LW_WORD, 1'b0,
                  32'h0, 0, 1'b1, 32'h0000_0321);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
